// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM responder: default geometry, the bundled
// request layout and small access-decode helpers.
package data_sram_resp_pkg;

  localparam int          DSRAM_ADDR_WIDTH = 14;
  localparam logic [31:0] DSRAM_BASE       = 32'h0000_0000;
  localparam int          DSRAM_REQ_LEN    = 69;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dsram_req_t;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_t;

  function automatic acc_kind_t decode_kind(input logic en, input logic [3:0] we);
    if (!en) begin
      return ACC_IDLE;
    end else if (we == 4'b0000) begin
      return ACC_READ;
    end else begin
      return ACC_WRITE;
    end
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_sram_bank.sv
// Single-port synchronous word RAM built from four byte-wide lanes so each
// lane maps onto its own block RAM write enable; read data is registered.
module data_sram_bank #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic w_rd;
  assign w_rd = i_en && (i_we == 4'b0000);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      // The read register only loads on read cycles, so write/read ordering
      // within one edge never matters.
      always_ff @(posedge clk) begin
        if (i_en && i_we[gi]) begin
          r_mem[i_addr] <= i_wdata[8*gi +: 8];
        end
        if (w_rd) begin
          r_q <= r_mem[i_addr];
        end
      end

      assign o_rdata[8*gi +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: range check, 1-cycle registered read return, sticky
// out-of-range flag and saturating access counters around data_sram_bank.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = DSRAM_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR  = DSRAM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        addr_err,
  input  logic        cnt_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  // One bit wider than the address so the span stays exact at large depths.
  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

  dsram_req_t            w_req;
  acc_kind_t             w_kind;
  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_ram_en;
  logic [31:0]           w_bank_rdata;
  logic [31:0]           w_rdata_out;

  logic                  r_rvalid;
  logic                  r_rd_oor;
  logic [31:0]           r_rdata_hold;
  logic                  r_addr_err;
  logic [31:0]           r_rd_cnt;
  logic [31:0]           r_wr_cnt;

  assign w_req = '{en: data_sram_en, we: data_sram_we,
                   addr: data_sram_addr, wdata: data_sram_wdata};

  assign w_kind     = decode_kind(w_req.en, w_req.we);
  assign w_off      = w_req.addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[ADDR_WIDTH+1:2];

  // Out-of-range and reset-cycle accesses never reach the RAM.
  assign w_ram_en = !reset && w_in_range && (w_kind != ACC_IDLE);

  data_sram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_req.we),
    .i_addr  (w_idx),
    .i_wdata (w_req.wdata),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid     <= 1'b0;
      r_rd_oor     <= 1'b0;
      r_rdata_hold <= 32'h0;
    end else begin
      r_rvalid <= (w_kind == ACC_READ);
      r_rd_oor <= !w_in_range;
      if (r_rvalid) begin
        r_rdata_hold <= w_rdata_out;
      end
    end
  end

  // Present fresh RAM data only in the rvalid cycle; otherwise hold the last result.
  assign w_rdata_out = r_rvalid ? (r_rd_oor ? 32'h0 : w_bank_rdata) : r_rdata_hold;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      r_rd_cnt   <= 32'h0;
      r_wr_cnt   <= 32'h0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_kind == ACC_READ) begin
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
      if (w_kind == ACC_WRITE) begin
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end
      if ((w_kind != ACC_IDLE) && !w_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign data_sram_rdata  = w_rdata_out;
  assign data_sram_rvalid = r_rvalid;
  assign addr_err         = r_addr_err;
  assign rd_cnt           = r_rd_cnt;
  assign wr_cnt           = r_wr_cnt;

endmodule
